// File: rtl/ppu_vram_port.sv
// ppu_vram_port
//   CPU-side initiator for PPU VRAM. Decodes PPUADDR ($2006) and PPUDATA ($2007)
//   accesses into a one-outstanding req/ack stream toward the VRAM mapper.
//   Owns the shared first/second write toggle, the VRAM address and the
//   PPUDATA read buffer.
//
// Optional feature macro: VRAM_PAL_READ_EN
//   defined   : palette-range reads (addr >= 3F00) return live palette data after
//               a CPU stall, then refill the buffer from addr-1000 (nametable mirror).
//   undefined : palette-range reads take the normal buffered read path.
//
// Ports
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   cs_i             CPU selects a PPU register this cycle
//   reg_sel_i[2:0]   register index (2=PPUSTATUS, 6=PPUADDR, 7=PPUDATA)
//   rw_i             1=read, 0=write
//   cpu_din_i[7:0]   CPU write data
//   cpu_dout_o[7:0]  PPUDATA read result (registered)
//   cpu_rdy_o        0 stalls the CPU; access accepted on cs_i && cpu_rdy_o
//   inc32_i          PPUCTRL bit 2 (address step 32 instead of 1)
//   w_latch_o        write toggle, shared with scroll logic
//   vram_req_o       request, held until vram_ack_i
//   vram_we_o        1=write request
//   vram_addr_o[15:0] {2'b00, addr}
//   vram_wdata_o[7:0] write data
//   vram_rdata_i[7:0] read data, valid with vram_ack_i
//   vram_ack_i       one-cycle completion pulse
module ppu_vram_port #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned INC_SMALL = 1,
  parameter int unsigned INC_LARGE = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cs_i,
  input  logic [2:0]  reg_sel_i,
  input  logic        rw_i,
  input  logic [7:0]  cpu_din_i,
  output logic [7:0]  cpu_dout_o,
  output logic        cpu_rdy_o,
  input  logic        inc32_i,
  output logic        w_latch_o,
  output logic        vram_req_o,
  output logic        vram_we_o,
  output logic [15:0] vram_addr_o,
  output logic [7:0]  vram_wdata_o,
  input  logic [7:0]  vram_rdata_i,
  input  logic        vram_ack_i
);

`ifdef VRAM_PAL_READ_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_PAL, S_PAL_DONE, S_FILL} state_e;
  localparam logic [ADDR_W-1:0] PAL_BASE = ADDR_W'('h3F00);
  localparam logic [ADDR_W-1:0] FILL_OFS = ADDR_W'('h1000);
  logic [7:0]        pal_q;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD} state_e;
`endif

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-9:0] t_hi_q;
  logic              w_q;
  logic [7:0]        rd_buf_q;
  logic [7:0]        cpu_dout_q;
  logic              req_q, we_q, inc32_q;
  logic [7:0]        wdata_q;

  logic              is_stat, is_addr, is_data, acc;
  logic [ADDR_W-1:0] addr_inc, addr_next, req_addr;

  assign is_stat = (reg_sel_i == 3'd2);
  assign is_addr = (reg_sel_i == 3'd6);
  assign is_data = (reg_sel_i == 3'd7);

  // Only $2006/$2007 stall while a transaction is open; PAL_DONE releases the
  // CPU read that has been held since the palette access started.
  always_comb begin
    cpu_rdy_o = 1'b1;
    if (state_q != S_IDLE && cs_i && (is_addr || is_data)) cpu_rdy_o = 1'b0;
`ifdef VRAM_PAL_READ_EN
    if (state_q == S_PAL_DONE) cpu_rdy_o = 1'b1;
`endif
  end

  assign acc       = cs_i && cpu_rdy_o;
  // Step size is latched at acceptance so a PPUCTRL write mid-transaction has no effect.
  assign addr_inc  = inc32_q ? ADDR_W'(INC_LARGE) : ADDR_W'(INC_SMALL);
  assign addr_next = addr_q + addr_inc;

  // Address is driven from registers only, so it is stable for the whole request.
`ifdef VRAM_PAL_READ_EN
  assign req_addr = (state_q == S_FILL) ? addr_q - FILL_OFS : addr_q;
`else
  assign req_addr = addr_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      t_hi_q     <= '0;
      w_q        <= 1'b0;
      rd_buf_q   <= '0;
      cpu_dout_q <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      inc32_q    <= 1'b0;
`ifdef VRAM_PAL_READ_EN
      pal_q      <= '0;
`endif
    end else begin
      // PPUSTATUS reads are never stalled and may clear the toggle in any state.
      if (acc && is_stat && rw_i) w_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (acc && is_addr && !rw_i) begin
            if (!w_q) begin
              t_hi_q <= cpu_din_i[ADDR_W-9:0];
              w_q    <= 1'b1;
            end else begin
              addr_q <= {t_hi_q, cpu_din_i};
              w_q    <= 1'b0;
            end
          end else if (acc && is_data) begin
            inc32_q <= inc32_i;
            req_q   <= 1'b1;
            if (!rw_i) begin
              we_q    <= 1'b1;
              wdata_q <= cpu_din_i;
              state_q <= S_WR;
            end
`ifdef VRAM_PAL_READ_EN
            else if (addr_q >= PAL_BASE) begin
              we_q    <= 1'b0;
              state_q <= S_PAL;
            end
`endif
            else begin
              // Buffered read: CPU gets the previous buffer contents now.
              we_q       <= 1'b0;
              cpu_dout_q <= rd_buf_q;
              state_q    <= S_RD;
            end
          end
        end
        S_WR: if (vram_ack_i) begin
          addr_q  <= addr_next;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          state_q <= S_IDLE;
        end
        S_RD: if (vram_ack_i) begin
          rd_buf_q <= vram_rdata_i;
          addr_q   <= addr_next;
          req_q    <= 1'b0;
          state_q  <= S_IDLE;
        end
`ifdef VRAM_PAL_READ_EN
        S_PAL: if (vram_ack_i) begin
          pal_q   <= vram_rdata_i;
          req_q   <= 1'b0;
          state_q <= S_PAL_DONE;
        end
        S_PAL_DONE: begin
          cpu_dout_q <= pal_q;
          req_q      <= 1'b1;
          state_q    <= S_FILL;
        end
        S_FILL: if (vram_ack_i) begin
          rd_buf_q <= vram_rdata_i;
          addr_q   <= addr_next;
          req_q    <= 1'b0;
          state_q  <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_dout_o   = cpu_dout_q;
  assign w_latch_o    = w_q;
  assign vram_req_o   = req_q;
  assign vram_we_o    = we_q;
  assign vram_wdata_o = wdata_q;
  assign vram_addr_o  = {{(16-ADDR_W){1'b0}}, req_addr};

endmodule

// File: tb/tb_ppu_vram_port.sv
module tb_ppu_vram_port;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cs = 1'b0, rw = 1'b0, inc32 = 1'b0;
  logic [2:0]  reg_sel = 3'd0;
  logic [7:0]  cpu_din = 8'd0;
  logic [7:0]  cpu_dout, vram_wdata;
  logic        cpu_rdy, w_latch, vram_req, vram_we;
  logic [15:0] vram_addr;
  logic [7:0]  vram_rdata = 8'd0;
  logic        vram_ack = 1'b0;

  ppu_vram_port dut (
    .clk_i(clk), .rst_n_i(rst_n), .cs_i(cs), .reg_sel_i(reg_sel), .rw_i(rw),
    .cpu_din_i(cpu_din), .cpu_dout_o(cpu_dout), .cpu_rdy_o(cpu_rdy), .inc32_i(inc32),
    .w_latch_o(w_latch), .vram_req_o(vram_req), .vram_we_o(vram_we),
    .vram_addr_o(vram_addr), .vram_wdata_o(vram_wdata), .vram_rdata_i(vram_rdata),
    .vram_ack_i(vram_ack)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic we; logic [13:0] addr; logic [7:0] wd; } req_t;

  int n_tests = 0, n_fail = 0;
  req_t       exp_req[$];
  logic [7:0] exp_dout[$];
  int         dout_cnt = 0, dout_seen = 0;
  int         last_stall = 0, pal_stall = 0;
  int         fixed_dly = -1;
  logic       resp_en = 1'b1, resp_in_req = 1'b0;

  // Memory seen by the responder, and the reference model's copy of it.
  logic [7:0] mem     [0:16383];
  logic [7:0] ref_mem [0:16383];

  // Reference model: architectural PPU register state.
  logic [13:0] m_addr = 14'd0;
  logic [5:0]  m_thi = 6'd0;
  logic        m_w = 1'b0;
  logic [7:0]  m_buf = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_mem(input logic [13:0] a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic sync;
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (cpu_rdy) break;
      n++;
      if (n > 400) begin
        chk("rdy_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  // One CPU access; must be called just after a rising edge. The model is
  // advanced at the accepting edge and expected responses are queued.
  task automatic cpu(input logic [2:0] sel, input logic r, input logic [7:0] d, input logic i32);
    int n;
    logic pal;
    logic [13:0] a, inc;
    req_t e;
    cs = 1'b1; reg_sel = sel; rw = r; cpu_din = d; inc32 = i32;
    wait_rdy(n);
    last_stall = n;
    @(posedge clk); #1;
    a = m_addr;
    inc = i32 ? 14'd32 : 14'd1;
    pal = 1'b0;
    if (sel == 3'd2 && r) m_w = 1'b0;
    if (sel == 3'd6 && !r) begin
      if (!m_w) begin m_thi = d[5:0]; m_w = 1'b1; end
      else begin m_addr = {m_thi, d}; m_w = 1'b0; end
    end
    if (sel == 3'd7) begin
      if (!r) begin
        e = '{we: 1'b1, addr: a, wd: d};
        exp_req.push_back(e);
        ref_mem[a] = d;
      end else begin
`ifdef VRAM_PAL_READ_EN
        if (a >= 14'h3F00) pal = 1'b1;
`endif
        e = '{we: 1'b0, addr: a, wd: 8'd0};
        exp_req.push_back(e);
        if (pal) begin
          e.addr = a - 14'h1000;
          exp_req.push_back(e);
          exp_dout.push_back(ref_mem[a]);
          m_buf = ref_mem[a - 14'h1000];
        end else begin
          exp_dout.push_back(m_buf);
          m_buf = ref_mem[a];
          dout_cnt++;
        end
      end
      m_addr = a + inc;
    end
    if (pal) begin
      wait_rdy(n);
      pal_stall = n;
      @(posedge clk); #1;
      dout_cnt++;
    end
    cs = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((exp_req.size() != 0 || vram_req) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(n), 32'd0);
    @(negedge clk);
    sync();
  endtask

  task automatic chk_idle_addr(input string nm, input logic [15:0] exp);
    drain();
    @(negedge clk);
    chk(nm, 32'(vram_addr), 32'(exp));
    sync();
  endtask

  task automatic set_addr(input logic [13:0] a);
    cpu(3'd6, 1'b0, {2'b00, a[13:8]}, 1'b0);
    cpu(3'd6, 1'b0, a[7:0], 1'b0);
  endtask

  // VRAM responder with per-request latency.
  initial begin : responder
    int cnt = 0;
    logic [13:0] a;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        vram_ack = 1'b0;
        if (vram_req) begin
          if (!resp_in_req) begin
            resp_in_req = 1'b1;
            cnt = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
          end
          if (cnt == 0) begin
            vram_ack = 1'b1;
            a = vram_addr[13:0];
            vram_rdata = mem[a];
            if (vram_we) mem[a] = vram_wdata;
          end else cnt--;
        end else resp_in_req = 1'b0;
      end
    end
  end

  // Monitor: compares requests and read data against the queued expectations.
  initial begin : monitor
    logic req_open = 1'b0;
    logic [15:0] cur_addr = 16'd0;
    req_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) req_open = 1'b0;
      else begin
        chk("w_latch", 32'(w_latch), 32'(m_w));
        if (vram_req) begin
          if (!req_open) begin
            req_open = 1'b1;
            cur_addr = vram_addr;
            if (exp_req.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL req_unexpected: got addr %0h, expected no request", vram_addr);
            end else begin
              e = exp_req.pop_front();
              chk("req_we", 32'(vram_we), 32'(e.we));
              chk("req_addr", 32'(vram_addr), 32'(e.addr));
              if (e.we) chk("req_wdata", 32'(vram_wdata), 32'(e.wd));
            end
          end else chk("req_stable", 32'(vram_addr), 32'(cur_addr));
        end else req_open = 1'b0;
        if (dout_cnt != dout_seen) begin
          dout_seen++;
          if (exp_dout.size() == 0) chk("dout_queue", 32'd0, 32'd1);
          else chk("cpu_dout", 32'(cpu_dout), 32'(exp_dout.pop_front()));
        end
      end
    end
  end

  initial begin : stim
    int op;
    logic [7:0] v;
    for (int i = 0; i < 16384; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(cpu_dout), 32'd0);
    chk("rst_req", 32'(vram_req), 32'd0);
    chk("rst_we", 32'(vram_we), 32'd0);
    chk("rst_wdata", 32'(vram_wdata), 32'd0);
    chk("rst_addr", 32'(vram_addr), 32'd0);
    chk("rst_w", 32'(w_latch), 32'd0);
    chk("rst_rdy", 32'(cpu_rdy), 32'd1);
    rst_n = 1'b1;
    sync();

    // 1: address pair, toggle behaviour
    cpu(3'd6, 1'b0, 8'h21, 1'b0);
    chk("t1_w_hi", 32'(w_latch), 32'd1);
    cpu(3'd6, 1'b0, 8'h08, 1'b0);
    chk("t1_w_lo", 32'(w_latch), 32'd0);
    chk_idle_addr("t1_addr", 16'h2108);

    // 2: data write and increment
    cpu(3'd7, 1'b0, 8'hAB, 1'b0);
    chk_idle_addr("t2_addr", 16'h2109);
    chk("t2_mem", 32'(mem[14'h2108]), 32'hAB);

    // 3: buffered reads, both increment sizes
    set_mem(14'h2000, 8'h11);
    set_mem(14'h2001, 8'h22);
    set_addr(14'h2000);
    cpu(3'd7, 1'b1, 8'h00, 1'b0);
    cpu(3'd7, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    chk("t3_dout_inc1", 32'(cpu_dout), 32'h11);
    sync();
    drain();
    set_addr(14'h2000);
    cpu(3'd7, 1'b1, 8'h00, 1'b1);
    cpu(3'd7, 1'b1, 8'h00, 1'b1);
    @(negedge clk);
    chk("t3_dout_inc32", 32'(cpu_dout), 32'h11);
    sync();
    chk_idle_addr("t3_addr", 16'h2040);

    // 4: palette-range read
    set_mem(14'h3F01, 8'h0F);
    set_mem(14'h2F01, 8'h5A);
    set_addr(14'h3F01);
    fixed_dly = 2;
    cpu(3'd7, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
`ifdef VRAM_PAL_READ_EN
    chk("t4_pal_dout", 32'(cpu_dout), 32'h0F);
    chk("t4_pal_stall", 32'(pal_stall), 32'd3);
`else
    chk("t4_no_stall", 32'(last_stall), 32'd0);
`endif
    sync();
    chk_idle_addr("t4_addr", 16'h3F02);
    set_addr(14'h2000);
    cpu(3'd7, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
`ifdef VRAM_PAL_READ_EN
    chk("t4_buf", 32'(cpu_dout), 32'h5A);
`else
    chk("t4_buf", 32'(cpu_dout), 32'h0F);
`endif
    sync();
    fixed_dly = -1;
    drain();

    // 5: toggle reset via PPUSTATUS, address wrap
    cpu(3'd6, 1'b0, 8'h3F, 1'b0);
    cpu(3'd2, 1'b1, 8'h00, 1'b0);
    chk("t5_w_clr", 32'(w_latch), 32'd0);
    cpu(3'd6, 1'b0, 8'h3F, 1'b0);
    chk("t5_w_hi", 32'(w_latch), 32'd1);
    cpu(3'd6, 1'b0, 8'hFF, 1'b0);
    chk_idle_addr("t5_addr", 16'h3FFF);
    cpu(3'd7, 1'b0, 8'h55, 1'b0);
    chk_idle_addr("t5_wrap", 16'h0000);

    // 6: slow ack, back-to-back writes stall the second
    fixed_dly = 5;
    cpu(3'd7, 1'b0, 8'h01, 1'b0);
    cpu(3'd7, 1'b0, 8'h02, 1'b0);
    chk("t6_stall", 32'(last_stall), 32'd6);
    fixed_dly = -1;
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1: begin
          v = 8'($urandom);
          if (!m_w && $urandom_range(0, 2) == 0) v = 8'h3F;
          cpu(3'd6, 1'b0, v, 1'b0);
        end
        2, 3: cpu(3'd7, 1'b0, 8'($urandom), 1'($urandom));
        4, 5, 6: cpu(3'd7, 1'b1, 8'h00, 1'($urandom));
        7: cpu(3'd2, 1'b1, 8'h00, 1'b0);
        8: cpu(3'($urandom_range(0, 1) == 0 ? 6 : 0), 1'b1, 8'($urandom), 1'b0);
        default: repeat ($urandom_range(1, 3)) sync();
      endcase
      repeat ($urandom_range(0, 2)) sync();
    end
    drain();
    chk("q_req_empty", 32'(exp_req.size()), 32'd0);
    chk("q_dout_empty", 32'(exp_dout.size()), 32'd0);

    // reset with a request open; a late ack must be ignored
    resp_en = 1'b0;
    vram_ack = 1'b0;
    cpu(3'd7, 1'b0, 8'h77, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("mid_req_open", 32'(vram_req), 32'd1);
    #2;
    rst_n = 1'b0;
    m_addr = 14'd0; m_w = 1'b0; m_buf = 8'd0; m_thi = 6'd0;
    #1;
    chk("mid_rst_req", 32'(vram_req), 32'd0);
    chk("mid_rst_we", 32'(vram_we), 32'd0);
    chk("mid_rst_wdata", 32'(vram_wdata), 32'd0);
    chk("mid_rst_addr", 32'(vram_addr), 32'd0);
    chk("mid_rst_dout", 32'(cpu_dout), 32'd0);
    chk("mid_rst_w", 32'(w_latch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vram_ack = 1'b1;
    @(negedge clk);
    vram_ack = 1'b0;
    #1;
    chk("late_ack_req", 32'(vram_req), 32'd0);
    chk("late_ack_addr", 32'(vram_addr), 32'd0);
    resp_in_req = 1'b0;
    resp_en = 1'b1;
    sync();
    cpu(3'd6, 1'b0, 8'h12, 1'b0);
    chk("post_rst_w", 32'(w_latch), 32'd1);
    repeat (2) sync();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
